// File: rtl/reg_dump_reader.sv
// -----------------------------------------------------------------------------
// reg_dump_reader
//
// Read-side companion to the processor register file. When START arrives it
// steps read port A1 through addresses FIRST_REG..LAST_REG. Each word is
// captured and offered as an (address, data) pair on a valid/ready stream.
// An XOR checksum of the accepted words is kept.
//
// The register-file read is combinational, so each word is captured in the
// cycle that presents its address (READ). It is then held in SEND until the
// sink accepts it. A word therefore reflects the register contents at its own
// READ cycle, even when the file is written while a dump is in progress.
//
// Ports
//   CLK         clock, rising edge
//   RESETn      synchronous active-low reset
//   START       one-cycle dump request, ignored while BUSY
//   RF_A        register-file read address (A1)
//   RF_RD       register-file read data (RD1), combinational from RF_A
//   DUMP_VALID  DUMP_ADDR/DUMP_DATA hold a word
//   DUMP_READY  sink accepts the word when DUMP_VALID is also high
//   DUMP_ADDR   register number of the current word
//   DUMP_DATA   captured register value
//   BUSY        high whenever not idle
//   DONE        one-cycle pulse after the last word is accepted
//   CHECKSUM    XOR of the words accepted in the current/most recent dump
// -----------------------------------------------------------------------------
module reg_dump_reader #(
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = 15
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        START,
  output logic [3:0]  RF_A,
  input  logic [31:0] RF_RD,
  output logic        DUMP_VALID,
  input  logic        DUMP_READY,
  output logic [3:0]  DUMP_ADDR,
  output logic [31:0] DUMP_DATA,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] CHECKSUM
);

  // An illegal address range is rejected at elaboration time.
  if ((FIRST_REG > LAST_REG) || (LAST_REG > 15)) begin : g_bad_range
    $error("reg_dump_reader: need FIRST_REG <= LAST_REG <= 15");
  end

  localparam logic [3:0] FIRST_A = FIRST_REG[3:0];
  localparam logic [3:0] LAST_A  = LAST_REG[3:0];

  typedef enum logic [1:0] {
    IDLE,
    READ,
    SEND,
    FIN
  } state_t;

  state_t state;

  // The handshake completes at this edge. Only SEND can hold a valid word.
  logic accept;
  assign accept = DUMP_VALID && DUMP_READY;

  // All outputs are registered here. BUSY and DONE are tracked explicitly
  // and not decoded from the state, so no output glitches on a state change.
  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples the values from before the edge, so RF_A, DUMP_ADDR and
  // CHECKSUM can be read and updated in the same cycle without ordering hazards.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state      <= IDLE;
      RF_A       <= FIRST_A;
      DUMP_VALID <= 1'b0;
      DUMP_ADDR  <= 4'd0;
      DUMP_DATA  <= 32'd0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      CHECKSUM   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            RF_A     <= FIRST_A;
            CHECKSUM <= 32'd0;
            BUSY     <= 1'b1;
            state    <= READ;
          end
        end

        // RF_RD is sampled only here, which pins each word to this cycle.
        READ: begin
          DUMP_DATA  <= RF_RD;
          DUMP_ADDR  <= RF_A;
          DUMP_VALID <= 1'b1;
          state      <= SEND;
        end

        // Without a handshake, nothing changes and the word stays stable.
        SEND: begin
          if (accept) begin
            CHECKSUM   <= CHECKSUM ^ DUMP_DATA;
            DUMP_VALID <= 1'b0;
            if (RF_A == LAST_A) begin
              // Stop before incrementing, so LAST_REG=15 never wraps to 0.
              DONE  <= 1'b1;
              state <= FIN;
            end else begin
              RF_A  <= RF_A + 4'd1;
              state <= READ;
            end
          end
        end

        FIN: begin
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// -----------------------------------------------------------------------------
// tb_reg_dump_reader
//
// Two instances share one register-file model: the default range (0..15) and
// a narrow range (2..4). For each dump, the stimulus side computes the expected
// word list, final checksum and, where timing is fixed, the DONE cycle. It
// pushes them into per-instance queues. A monitor on the falling edge pops and
// compares every accepted word and every DONE pulse. It also checks that words
// stay stable while stalled and that valid drops between words.
// -----------------------------------------------------------------------------
module tb_reg_dump_reader;

  typedef struct packed {
    logic [3:0]  addr;
    logic [31:0] data;
  } word_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  start;
  logic [1:0]  ready;
  logic [1:0]  valid;
  logic [1:0]  busy;
  logic [1:0]  done;
  logic [3:0]  rf_a      [2];
  logic [31:0] rf_rd     [2];
  logic [3:0]  dump_addr [2];
  logic [31:0] dump_data [2];
  logic [31:0] checksum  [2];

  // Register file model: R0..R14 storage, with R15 supplied as an input value.
  logic [31:0] regs [16];
  logic [31:0] r15;

  assign rf_rd[0] = (rf_a[0] == 4'd15) ? r15 : regs[rf_a[0]];
  assign rf_rd[1] = (rf_a[1] == 4'd15) ? r15 : regs[rf_a[1]];

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  reg_dump_reader dut0 (
    .CLK(clk), .RESETn(rst_n), .START(start[0]), .RF_A(rf_a[0]),
    .RF_RD(rf_rd[0]), .DUMP_VALID(valid[0]), .DUMP_READY(ready[0]),
    .DUMP_ADDR(dump_addr[0]), .DUMP_DATA(dump_data[0]), .BUSY(busy[0]),
    .DONE(done[0]), .CHECKSUM(checksum[0])
  );

  reg_dump_reader #(.FIRST_REG(2), .LAST_REG(4)) dut1 (
    .CLK(clk), .RESETn(rst_n), .START(start[1]), .RF_A(rf_a[1]),
    .RF_RD(rf_rd[1]), .DUMP_VALID(valid[1]), .DUMP_READY(ready[1]),
    .DUMP_ADDR(dump_addr[1]), .DUMP_DATA(dump_data[1]), .BUSY(busy[1]),
    .DONE(done[1]), .CHECKSUM(checksum[1])
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard ----------------
  word_t       exp_q     [2][$];
  logic [31:0] exp_sum_q [2][$];
  int          exp_cyc_q [2][$];
  logic [31:0] last_sum  [2];
  int          done_cnt  [2];
  int          first_reg [2];
  int          last_reg  [2];

  // Expected dump from the register contents, optionally with one register
  // rewritten before its READ cycle. fixed_timing=1 predicts the DONE cycle
  // for a sink that is always ready: READ+SEND per word, then FIN.
  task automatic start_dump(input int k, input bit fixed_timing,
                            input bit ov_en, input int ov_addr, input logic [31:0] ov_data);
    logic [31:0] sum;
    logic [31:0] d;
    word_t w;
    int n;
    sum = 32'd0;
    n = last_reg[k] - first_reg[k] + 1;
    for (int a = first_reg[k]; a <= last_reg[k]; a++) begin
      if (ov_en && a == ov_addr) d = ov_data;
      else if (a == 15)          d = r15;
      else                       d = regs[a];
      w.addr = a[3:0];
      w.data = d;
      exp_q[k].push_back(w);
      sum ^= d;
    end
    exp_sum_q[k].push_back(sum);
    exp_cyc_q[k].push_back(fixed_timing ? (cyc + 1 + 2 * n) : -1);
    last_sum[k] = sum;
    start[k] = 1'b1;
  endtask

  // ---------------- monitor ----------------
  logic [1:0]  gap_req = 2'b00;
  logic [1:0]  hold_v  = 2'b00;
  logic [3:0]  hold_a [2];
  logic [31:0] hold_d [2];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (gap_req[k]) begin
        check($sformatf("valid gap after word [%0d]", k), {31'd0, valid[k]}, 32'd0);
        gap_req[k] = 1'b0;
      end
      if (hold_v[k] && valid[k]) begin
        check($sformatf("stall addr stable [%0d]", k), {28'd0, dump_addr[k]}, {28'd0, hold_a[k]});
        check($sformatf("stall data stable [%0d]", k), dump_data[k], hold_d[k]);
      end
      hold_v[k] = 1'b0;
      if (valid[k] && ready[k]) begin
        check($sformatf("word expected [%0d]", k), {31'd0, exp_q[k].size() > 0}, 32'd1);
        if (exp_q[k].size() > 0) begin
          word_t w;
          w = exp_q[k].pop_front();
          check($sformatf("word addr [%0d]", k), {28'd0, dump_addr[k]}, {28'd0, w.addr});
          check($sformatf("word data [%0d] r%0d", k, w.addr), dump_data[k], w.data);
        end
        gap_req[k] = 1'b1;
      end else if (valid[k]) begin
        hold_v[k] = 1'b1;
        hold_a[k] = dump_addr[k];
        hold_d[k] = dump_data[k];
      end
      if (done[k]) begin
        done_cnt[k]++;
        check($sformatf("done expected [%0d]", k), {31'd0, exp_sum_q[k].size() > 0}, 32'd1);
        check($sformatf("all words before done [%0d]", k), exp_q[k].size(), 32'd0);
        if (exp_sum_q[k].size() > 0) begin
          int ec;
          check($sformatf("checksum at done [%0d]", k), checksum[k], exp_sum_q[k].pop_front());
          ec = exp_cyc_q[k].pop_front();
          if (ec >= 0) check($sformatf("done cycle [%0d]", k), cyc, ec);
        end
      end
    end
  end

  // ---------------- sink ready driver ----------------
  // 0: always ready, 1: ready one cycle in three, 2: random, 3: driven by stimulus
  int ready_mode [2];
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        case (ready_mode[k])
          0: ready[k] = 1'b1;
          1: ready[k] = (cyc % 3 == 0);
          2: ready[k] = 1'($urandom % 2);
          default: ;
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int k, input int n_before);
    int i;
    i = 0;
    while (done_cnt[k] == n_before && i < 400) begin
      tick();
      i++;
    end
    check($sformatf("done within budget [%0d]", k), {31'd0, done_cnt[k] > n_before}, 32'd1);
  endtask

  task automatic check_reset_outputs(input int k);
    check($sformatf("reset rf_a [%0d]", k), {28'd0, rf_a[k]}, first_reg[k]);
    check($sformatf("reset valid [%0d]", k), {31'd0, valid[k]}, 32'd0);
    check($sformatf("reset addr [%0d]", k), {28'd0, dump_addr[k]}, 32'd0);
    check($sformatf("reset data [%0d]", k), dump_data[k], 32'd0);
    check($sformatf("reset busy [%0d]", k), {31'd0, busy[k]}, 32'd0);
    check($sformatf("reset done [%0d]", k), {31'd0, done[k]}, 32'd0);
    check($sformatf("reset checksum [%0d]", k), checksum[k], 32'd0);
  endtask

  task automatic check_idle_after(input int k);
    tick();
    tick();
    check($sformatf("idle busy [%0d]", k), {31'd0, busy[k]}, 32'd0);
    check($sformatf("checksum holds [%0d]", k), checksum[k], last_sum[k]);
  endtask

  task automatic load_pattern();
    regs[0] = 32'd0;
    for (int n = 1; n <= 14; n++) regs[n] = 32'((n - 1) * 'h11);
    regs[15] = 32'd0;
    r15 = 32'h0000_0008;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, n1;
    first_reg[0] = 0;  last_reg[0] = 15;
    first_reg[1] = 2;  last_reg[1] = 4;
    done_cnt[0] = 0;   done_cnt[1] = 0;
    ready_mode[0] = 0; ready_mode[1] = 0;
    start = 2'b00;
    ready = 2'b11;
    rst_n = 1'b0;
    load_pattern();

    // Reset state for both instances.
    repeat (3) tick();
    check_reset_outputs(0);
    check_reset_outputs(1);
    rst_n = 1'b1;
    tick();

    // Full default dump with an always-ready sink.
    n0 = done_cnt[0];
    start_dump(0, 1'b1, 1'b0, 0, 32'd0);
    tick();
    start[0] = 1'b0;
    check("busy after start", {31'd0, busy[0]}, 32'd1);
    wait_done(0, n0);
    check_idle_after(0);

    // Same dump with the sink ready only one cycle in three.
    ready_mode[0] = 1;
    n0 = done_cnt[0];
    start_dump(0, 1'b0, 1'b0, 0, 32'd0);
    tick();
    start[0] = 1'b0;
    wait_done(0, n0);
    check_idle_after(0);
    ready_mode[0] = 0;

    // Narrow range 2..4.
    n1 = done_cnt[1];
    start_dump(1, 1'b1, 1'b0, 0, 32'd0);
    tick();
    start[1] = 1'b0;
    wait_done(1, n1);
    check_idle_after(1);

    // START pulses mid-dump are ignored: no restart, one DONE.
    n0 = done_cnt[0];
    start_dump(0, 1'b1, 1'b0, 0, 32'd0);
    tick();
    start[0] = 1'b0;
    tick();
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    repeat (6) tick();
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    wait_done(0, n0);
    repeat (40) tick();
    check("single done despite restarts", done_cnt[0], n0 + 1);
    check("idle after ignored starts", {31'd0, busy[0]}, 32'd0);

    // Reset while word 5 is held in SEND.
    ready_mode[0] = 3;
    ready[0] = 1'b1;
    start_dump(0, 1'b0, 1'b0, 0, 32'd0);
    tick();
    start[0] = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (valid[0] && dump_addr[0] == 4'd5) break;
      tick();
    end
    ready[0] = 1'b0;
    check("holding word 5", {31'd0, valid[0] && dump_addr[0] == 4'd5}, 32'd1);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q[0].delete();
    exp_sum_q[0].delete();
    exp_cyc_q[0].delete();
    check_reset_outputs(0);
    ready_mode[0] = 0;
    tick();
    n0 = done_cnt[0];
    start_dump(0, 1'b1, 1'b0, 0, 32'd0);
    tick();
    start[0] = 1'b0;
    check("checksum cleared on start", checksum[0], 32'd0);
    wait_done(0, n0);
    check_idle_after(0);

    // R3 rewritten during R2's SEND cycle; the dump must carry the new value.
    n0 = done_cnt[0];
    start_dump(0, 1'b1, 1'b1, 3, 32'hDEAD_BEEF);
    tick();
    start[0] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (valid[0] && dump_addr[0] == 4'd2) break;
      tick();
    end
    check("reached R2 send", {31'd0, valid[0] && dump_addr[0] == 4'd2}, 32'd1);
    regs[3] = 32'hDEAD_BEEF;
    wait_done(0, n0);
    check_idle_after(0);

    // Random register contents and random sink back-pressure on both instances.
    for (int it = 0; it < 6; it++) begin
      for (int n = 0; n < 15; n++) regs[n] = $urandom;
      r15 = $urandom;
      ready_mode[0] = 1 + int'($urandom_range(1));
      ready_mode[1] = 1 + int'($urandom_range(1));
      n0 = done_cnt[0];
      n1 = done_cnt[1];
      start_dump(0, 1'b0, 1'b0, 0, 32'd0);
      start_dump(1, 1'b0, 1'b0, 0, 32'd0);
      tick();
      start = 2'b00;
      wait_done(0, n0);
      wait_done(1, n1);
      check_idle_after(0);
      check_idle_after(1);
    end

    repeat (5) tick();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("no leftover words [%0d]", k), exp_q[k].size(), 32'd0);
      check($sformatf("no leftover dones [%0d]", k), exp_sum_q[k].size(), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
